alu_share_ctrl: RTL and testbench
=================================

// Module: alu_share_ctrl
// PURPOSE
//   Shares one registered ALU/compare unit (1-cycle, enable-qualified) between two command requesters.
//   Round-robin arbitration; sequences operand issue, enable pulse and result capture; one command in flight.
//   Owns the unit's clock-gate enable: releases it after an idle timeout, re-wakes it on demand.
//   Sits between the system controller request paths and the ALU block.
// PARAMETERS
//   WIDTH          16  operand/result width
//   FUN_W           4  ALU function code width
//   IDLE_GATE_CYC   4  consecutive idle cycles before alu_clk_en drops (legal >= 1)
// PORTS
//   clk         in   1      system clock
//   rst         in   1      asynchronous reset, active-low
//   reqN_valid  in   1      requester N (N=0,1) command valid
//   reqN_ready  out  1      requester N command accepted this cycle
//   reqN_a      in   WIDTH  requester N operand A
//   reqN_b      in   WIDTH  requester N operand B
//   reqN_fun    in   FUN_W  requester N function code
//   alu_a       out  WIDTH  operand A to ALU
//   alu_b       out  WIDTH  operand B to ALU
//   alu_fun     out  FUN_W  function code to ALU
//   alu_enable  out  1      ALU enable; high exactly one cycle per command
//   alu_clk_en  out  1      ALU clock-gate enable
//   alu_out     in   WIDTH  ALU registered result
//   alu_flag    in   1      ALU registered flag
//   rsp_valid   out  1      response valid
//   rsp_ready   in   1      response consumer ready
//   rsp_id      out  1      requester index owning the response
//   rsp_data    out  WIDTH  captured alu_out
//   rsp_flag    out  1      captured alu_flag
// BEHAVIOUR
//   Reset: every output 0; state IDLE; last_grant=1 (req0 wins first); idle counter 0.
//   Reset is honoured in any state; an in-flight command is dropped, no response.
//   FSM: IDLE -> (WAKE) -> ISSUE -> CAPTURE -> RESP -> IDLE.
//   IDLE: reqN_ready combinational; only the granted requester, only in IDLE; never both in one cycle.
//     Grant: sole valid requester wins; both valid -> requester != last_grant wins.
//     Accept edge: latch a/b/fun/id, update last_grant; alu_clk_en=1 -> ISSUE, alu_clk_en=0 -> WAKE.
//   WAKE: alu_clk_en rises on entry; one cycle; -> ISSUE.
//   ISSUE: alu_enable=1 for this single cycle; alu_a/b/fun = latched values; -> CAPTURE.
//   CAPTURE: alu_enable=0; operands held; rsp_data/rsp_flag <= alu_out/alu_flag at end of cycle; -> RESP.
//   RESP: rsp_valid=1; rsp_id/data/flag stable until rsp_ready; handshake edge -> IDLE, rsp_valid=0.
//     rsp_ready ignored outside RESP.
//   Latency with clock awake: rsp_valid high 3 cycles after accept edge; 4 when a WAKE is needed.
//   Throughput: 1 command per 4 cycles min (ready again the cycle after response handshake).
//   alu_a/b/fun hold last issued values when idle; no toggling without commands.
//   Clock gate: idle counter counts IDLE cycles with both reqN_valid low; any other state or valid clears it.
//     Counter reaches IDLE_GATE_CYC -> alu_clk_en <= 0; counter saturates.
//     alu_clk_en never drops outside IDLE or on a cycle with a reqN_valid high.
//   Simultaneous: accept on the same cycle the counter would expire -> accept wins, clk_en stays 1.
// TESTING
//   req0 a=5 b=5 fun=4'b0001, clk awake -> ISSUE 1 cycle after accept; rsp_valid 3 cycles after; id=0 data=1 flag=1.
//   req0 and req1 valid together, twice -> order req0,req1,req0,req1; exactly one ready per IDLE cycle.
//   No requests 4 cycles -> alu_clk_en=0 on 5th; req1 a=9 b=3 fun=4'b0010 -> WAKE; rsp 4 cycles later, data=1 flag=1.
//   rsp_ready low 5 cycles in RESP -> rsp_* stable, both reqN_ready=0, alu_enable=0; then handshake -> IDLE.
//   rst low during CAPTURE -> all outputs 0 immediately; no rsp_valid after release; next grant goes to req0.
//   req0 a=2 b=7 fun=4'b0011 then fun=4'b0000 -> rsp data=1 flag=1 both; alu_enable pulses exactly once each.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one registered, enable-qualified ALU between two
// command requesters. It runs round-robin arbitration and keeps one command
// in flight. It sequences operand issue, the enable pulse and result capture.
// It also owns the ALU clock-gate enable: the enable drops after an idle
// timeout and is raised again when a command is accepted.
module alu_share_ctrl #(
  parameter int WIDTH         = 16,
  parameter int FUN_W         = 4,
  parameter int IDLE_GATE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [FUN_W-1:0] req0_fun,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [FUN_W-1:0] req1_fun,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [FUN_W-1:0] alu_fun,
  output logic             alu_enable,
  output logic             alu_clk_en,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_flag
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAKE    = 3'd1,
    S_ISSUE   = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(IDLE_GATE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(IDLE_GATE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_GATE_CYC - 1);

  state_t           state, state_nxt;
  logic             last_grant;
  logic             gnt0, gnt1, accept, idle_now;
  logic [CNT_W-1:0] idle_cnt;

  // Arbitration, handshakes and next-state decode.
  // The ready outputs are also gated by rst, so they stay low during reset.
  always_comb begin
    gnt1       = req1_valid && (!req0_valid || !last_grant);
    gnt0       = req0_valid && !gnt1;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    alu_enable = 1'b0;
    rsp_valid  = 1'b0;
    state_nxt  = state;
    case (state)
      S_IDLE: begin
        req0_ready = rst && gnt0;
        req1_ready = rst && gnt1;
        if (req0_ready || req1_ready)
          state_nxt = alu_clk_en ? S_ISSUE : S_WAKE;
      end
      S_WAKE:    state_nxt = S_ISSUE;
      S_ISSUE: begin
        alu_enable = 1'b1;
        state_nxt  = S_CAPTURE;
      end
      S_CAPTURE: state_nxt = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default:   state_nxt = S_IDLE;
    endcase
    accept   = req0_ready || req1_ready;
    idle_now = (state == S_IDLE) && !req0_valid && !req1_valid;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Latch the granted command on the accept edge. The operands stay on the
  // ALU inputs until the next accept, so they do not toggle while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_fun    <= '0;
      rsp_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      alu_a      <= gnt1 ? req1_a : req0_a;
      alu_b      <= gnt1 ? req1_b : req0_b;
      alu_fun    <= gnt1 ? req1_fun : req0_fun;
      rsp_id     <= gnt1;
      last_grant <= gnt1;
    end
  end

  // Capture the ALU's registered result one cycle after the enable pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_data <= '0;
      rsp_flag <= 1'b0;
    end else if (state == S_CAPTURE) begin
      rsp_data <= alu_out;
      rsp_flag <= alu_flag;
    end
  end

  // Idle timeout for the clock gate. The enable drops on the edge where the
  // count reaches the limit, and that can only happen in a quiet IDLE cycle.
  // An accept raises it again, and that is the cycle spent in WAKE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt   <= '0;
      alu_clk_en <= 1'b0;
    end else begin
      if (idle_now) begin
        if (idle_cnt != CNT_MAX) idle_cnt <= idle_cnt + CNT_W'(1);
        if (idle_cnt >= CNT_LAST) alu_clk_en <= 1'b0;
      end else begin
        idle_cnt <= '0;
      end
      if (accept && !alu_clk_en) alu_clk_en <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Testbench for alu_share_ctrl. A small behavioural ALU model is attached to
// the DUT. Directed command vectors are checked from a table, and
// hand-written sequences cover arbitration, idle gating and mid-flight reset.
module tb_alu_share_ctrl;

  localparam int WIDTH = 16;
  localparam int FUN_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [FUN_W-1:0] req0_fun, req1_fun;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [FUN_W-1:0] alu_fun;
  logic             alu_enable, alu_clk_en;
  logic [WIDTH-1:0] alu_out = '0;
  logic             alu_flag = 1'b0;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_flag;
  logic [WIDTH-1:0] rsp_data;

  int total = 0;
  int passed = 0;

  alu_share_ctrl #(.WIDTH(WIDTH), .FUN_W(FUN_W), .IDLE_GATE_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_fun(req0_fun),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_fun(req1_fun),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
    .alu_enable(alu_enable), .alu_clk_en(alu_clk_en),
    .alu_out(alu_out), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flag(rsp_flag)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: 0 NE, 1 EQ, 2 GT, 3 LT, 4 ADD, 5 SUB; flag = result nonzero.
  function automatic logic [WIDTH-1:0] alu_f(input logic [WIDTH-1:0] a, b,
                                             input logic [FUN_W-1:0] f);
    case (f)
      4'd0:    return {15'd0, a != b};
      4'd1:    return {15'd0, a == b};
      4'd2:    return {15'd0, a > b};
      4'd3:    return {15'd0, a < b};
      4'd4:    return a + b;
      4'd5:    return a - b;
      default: return '0;
    endcase
  endfunction

  // The ALU only updates when both the enable pulse and the clock gate are up.
  always_ff @(posedge clk) begin
    if (alu_enable && alu_clk_en) begin
      alu_out  <= alu_f(alu_a, alu_b, alu_fun);
      alu_flag <= (alu_f(alu_a, alu_b, alu_fun) != '0);
    end
  end

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [FUN_W-1:0] fun;
    logic             wake;
    logic [3:0]       hold;
    logic [WIDTH-1:0] d;
    logic             f;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Runs one command. It is entered just after a negedge while the DUT is in
  // IDLE, and it returns at the negedge of the first IDLE cycle after the
  // response handshake.
  task automatic do_cmd(input vec_t v);
    int n, k, pulses, lat;
    logic rdy, other;
    if (v.id) begin
      req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_fun = v.fun;
    end else begin
      req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_fun = v.fun;
    end
    #1;
    n = 0;
    rdy = v.id ? req1_ready : req0_ready;
    while (!rdy && n < 20) begin
      @(negedge clk); #1; n++;
      rdy = v.id ? req1_ready : req0_ready;
    end
    chk("ready_seen", {31'd0, rdy}, 32'd1);
    other = v.id ? req0_ready : req1_ready;
    chk("other_ready_low", {31'd0, other}, 32'd0);
    chk("clk_en_before_accept", {31'd0, alu_clk_en}, {31'd0, !v.wake});
    @(posedge clk);
    k = 0; pulses = 0; lat = 0;
    repeat (12) begin
      @(negedge clk); k++;
      if (k == 1) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      if (alu_enable) begin
        pulses++;
        chk("issue_a", {16'd0, alu_a}, {16'd0, v.a});
        chk("issue_b", {16'd0, alu_b}, {16'd0, v.b});
        chk("issue_fun", {28'd0, alu_fun}, {28'd0, v.fun});
        chk("issue_clk_en", {31'd0, alu_clk_en}, 32'd1);
      end
      if (rsp_valid) begin lat = k; break; end
    end
    chk("rsp_latency", lat, v.wake ? 32'd4 : 32'd3);
    chk("enable_pulses", pulses, 32'd1);
    chk("rsp_id", {31'd0, rsp_id}, {31'd0, v.id});
    chk("rsp_data", {16'd0, rsp_data}, {16'd0, v.d});
    chk("rsp_flag", {31'd0, rsp_flag}, {31'd0, v.f});
    if (v.hold != 0) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < int'(v.hold); i++) begin
        #1;
        chk("hold_readys", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("hold_enable", {31'd0, alu_enable}, 32'd0);
        chk("hold_rsp", {14'd0, rsp_valid, rsp_id, rsp_data, rsp_flag},
            {14'd0, 1'b1, v.id, v.d, v.f});
        @(negedge clk);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", {31'd0, rsp_valid}, 32'd0);
  endtask

  vec_t vecs[6];
  vec_t vw, vs;
  int   grants[4];
  int   ng, dual, seen;

  initial begin
    vecs[0] = '{id:1'b0, a:16'd5,     b:16'd5,     fun:4'd1, wake:1'b0, hold:4'd0, d:16'd1,     f:1'b1};
    vecs[1] = '{id:1'b0, a:16'd2,     b:16'd7,     fun:4'd3, wake:1'b0, hold:4'd0, d:16'd1,     f:1'b1};
    vecs[2] = '{id:1'b0, a:16'd2,     b:16'd7,     fun:4'd0, wake:1'b0, hold:4'd0, d:16'd1,     f:1'b1};
    vecs[3] = '{id:1'b1, a:16'h1234,  b:16'h0101,  fun:4'd4, wake:1'b0, hold:4'd5, d:16'h1335,  f:1'b1};
    vecs[4] = '{id:1'b1, a:16'd5,     b:16'd5,     fun:4'd5, wake:1'b0, hold:4'd0, d:16'd0,     f:1'b0};
    vecs[5] = '{id:1'b0, a:16'h00FF,  b:16'h0001,  fun:4'd4, wake:1'b0, hold:4'd0, d:16'h0100,  f:1'b1};
    vw      = '{id:1'b1, a:16'd9,     b:16'd3,     fun:4'd2, wake:1'b1, hold:4'd0, d:16'd1,     f:1'b1};
    vs      = '{id:1'b0, a:16'd4,     b:16'd4,     fun:4'd1, wake:1'b0, hold:4'd0, d:16'd1,     f:1'b1};

    rst = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = 16'd1; req0_b = 16'd1; req0_fun = 4'd1;
    req1_a = 16'd1; req1_b = 16'd1; req1_fun = 4'd1;
    // Reset state, with a request pending to show that ready stays low.
    repeat (2) @(negedge clk);
    chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    chk("rst_alu", {12'd0, alu_a, alu_fun}, 32'd0);
    chk("rst_ctrl", {29'd0, alu_enable, alu_clk_en, rsp_valid}, 32'd0);
    chk("rst_rsp", {14'd0, rsp_id, rsp_data, rsp_flag, alu_b[0]}, 32'd0);
    req0_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // Round-robin with both requesters valid the whole time.
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    ng = 0; dual = 0;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      #1;
      if (req0_ready && req1_ready) dual++;
      if (req0_ready || req1_ready) begin
        grants[ng] = req1_ready ? 1 : 0;
        ng++;
      end
      if (ng < 4) @(negedge clk);
    end
    chk("arb_grant_count", ng, 32'd4);
    chk("arb_dual_ready", dual, 32'd0);
    for (int i = 0; i < 4; i++)
      chk("arb_order", grants[i], (i % 2 == 0) ? 32'd0 : 32'd1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      if (rsp_valid) seen = 1;
      else @(negedge clk);
    end
    chk("arb_last_rsp", seen, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;

    // Table-driven single commands with the clock awake.
    for (int i = 0; i < 6; i++) do_cmd(vecs[i]);

    // Idle timeout: the gate is up for four quiet IDLE cycles and down on the
    // fifth. The operands hold their last values.
    for (int c = 1; c <= 5; c++) begin
      chk("idle_clk_en", {31'd0, alu_clk_en}, (c == 5) ? 32'd0 : 32'd1);
      if (c < 5) @(negedge clk);
    end
    chk("idle_hold_a", {16'd0, alu_a}, 32'h00FF);
    do_cmd(vw);

    // A request on the cycle where the timer would expire keeps the gate up.
    repeat (3) @(negedge clk);
    do_cmd(vs);

    // Reset during CAPTURE drops the command; the next grant goes to req0.
    req0_valid = 1'b1; req0_a = 16'h0A0B; req0_b = 16'd3; req0_fun = 4'd4;
    #1;
    chk("rstcap_accept", {31'd0, req0_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstcap_alu", {12'd0, alu_a, alu_fun}, 32'd0);
    chk("rstcap_ctrl", {29'd0, alu_enable, alu_clk_en, rsp_valid}, 32'd0);
    chk("rstcap_rsp", {15'd0, rsp_id, rsp_data}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("rstcap_no_rsp", seen, 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rstcap_next_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
